ssd_scan_multi: RTL

//  Parametrised multiplexed seven-segment scanner, successor to the fixed 4-digit scan block.

---
 rtl/ssd_pkg.sv | 11 +
 rtl/ssd_hex_decoder.sv | 15 +
 rtl/ssd_scan_multi.sv | 101 ++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared state encoding, segment bit indices and hex->segment table for the scanner
package ssd_pkg;
  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_e;
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: nibble plus decimal point to active-high dp,g..a segment pattern
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  // table lookup, decimal point on the top bit
  always_comb begin
    seg = '0;
    seg[SEG_G:SEG_A] = HEX_SEG[nib];
    seg[SEG_DP] = dp;
  end
endmodule

// File: rtl/ssd_scan_multi.sv
// ssd_scan_multi: multiplexed seven-segment scanner with dead time, PWM and frame-synchronous load; SSD_LZ_SUPPRESS_EN enables leading-zero suppression
module ssd_scan_multi
  import ssd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD,
  input  logic [3:0]            BRIGHTNESS,
  output logic [7:0]            OUTPUT_SEG,
  output logic [DIGITS-1:0]     OUTPUT_SEL,
  output logic                  SCAN_CLK,
  output logic                  FRAME_DONE
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = 5 * DIGITS + 1;
  localparam logic [31:0] BLANK_U = BLANK_CYCLES;
  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  state_e state_q, state_d;
  logic wrap_q, wrap_d;
  logic [PW-1:0] pending_q, pending_d, active_q, active_d;
  logic [7:0] seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic scan_clk_q, scan_clk_d, frame_done_q, frame_done_d;
  logic wrap, lz_blank, lit;
  logic [3:0] pwm;
  logic [7:0] seg_hi;
  logic [DIGITS-1:0] sel_hi;
  logic act_vld;
  logic [DIGITS-1:0] act_dp;
  logic [4*DIGITS-1:0] act_data;
  assign act_vld  = active_q[PW-1];
  assign act_dp   = active_q[5*DIGITS-1:4*DIGITS];
  assign act_data = active_q[4*DIGITS-1:0];
  ssd_hex_decoder u_dec (
    .nib (act_data[{idx_q, 2'b00} +: 4]),
    .dp  (act_dp[idx_q]),
    .seg (seg_hi)
  );
  // slot timing, digit index, frame-synchronous data transfer and pin patterns
  always_comb begin
    wrap = slot_cnt_q == CW'(CLK_DIV - 1);
    slot_cnt_d = wrap ? '0 : slot_cnt_q + CW'(1);
    idx_d = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    state_d = 32'(slot_cnt_d) < BLANK_U ? ST_BLANK : ST_ON;
    wrap_d = wrap;
    pending_d = LOAD ? {1'b1, DP_IN, DATA} : pending_q;
    active_d = (wrap && idx_q == IW'(DIGITS - 1)) ? pending_d : active_q;
`ifdef SSD_LZ_SUPPRESS_EN
    lz_blank = idx_q != '0 && (act_data >> {idx_q, 2'b00}) == '0 && !act_dp[idx_q];
`else
    lz_blank = 1'b0;
`endif
    pwm = 4'(slot_cnt_q) - 4'(BLANK_CYCLES);
    lit = state_q == ST_ON && act_vld && !lz_blank && pwm <= BRIGHTNESS;
    sel_hi = state_q == ST_ON ? DIGITS'(1) << idx_q : '0;
    seg_d = SEG_ACTIVE_LOW ? ~(lit ? seg_hi : 8'h00) : (lit ? seg_hi : 8'h00);
    sel_d = SEL_ACTIVE_LOW ? ~sel_hi : sel_hi;
    scan_clk_d = wrap_q;
    frame_done_d = wrap_q && idx_q == '0;
  end
  // state and registered pins; reset aborts the slot and drops both data registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      wrap_q       <= 1'b0;
      pending_q    <= '0;
      active_q     <= '0;
      seg_q        <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
      sel_q        <= SEL_ACTIVE_LOW ? '1 : '0;
      scan_clk_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      wrap_q       <= wrap_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      scan_clk_q   <= scan_clk_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign OUTPUT_SEG = seg_q;
  assign OUTPUT_SEL = sel_q;
  assign SCAN_CLK   = scan_clk_q;
  assign FRAME_DONE = frame_done_q;
endmodule
